// File: rtl/mlp_acc_bias_relu.sv
// ============================================================================
// Module   : mlp_acc_bias_relu
// Brief    : Per-lane neuron accumulator: sums a product stream, adds bias,
//            saturates, applies ReLU, holds the result behind valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mlp_acc_bias_relu #(
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 24,
   parameter int N_INPUTS = 8,
   parameter int CNT_W    = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ce,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_last,
   input  logic signed [DATA_W-1:0] bias,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic        [DATA_W-1:0] out_data,
   output logic        [CNT_W-1:0]  beat_cnt,
   output logic                     err_len
);

   localparam int SUM_W = ACC_W + 1;
   localparam logic signed [SUM_W-1:0] c_POS_MAX = SUM_W'(2 ** (DATA_W - 1) - 1);
   localparam logic        [CNT_W:0]   c_N       = (CNT_W + 1)'(N_INPUTS);
   localparam logic        [CNT_W-1:0] c_CNT_MAX = '1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [ACC_W-1:0]   w_acc_nxt;
   logic        [CNT_W-1:0]   r_cnt;
   logic        [CNT_W-1:0]   w_cnt_nxt;
   logic                      r_out_valid;
   logic        [DATA_W-1:0]  r_out_data;
   logic                      r_err;

   logic                      w_in_ready;
   logic                      w_in_fire;
   logic                      w_out_fire;
   logic                      w_load;
   logic signed [ACC_W-1:0]   w_acc_base;
   logic signed [SUM_W-1:0]   w_sum;
   logic        [DATA_W-1:0]  w_result;
   logic        [CNT_W:0]     w_cnt_p1;
   logic                      w_len_err;

   // A full result register only blocks input when downstream is not draining it.
   assign w_in_ready = ~r_out_valid | out_ready;
   assign w_in_fire  = ce & in_valid & w_in_ready;
   assign w_out_fire = ce & r_out_valid & out_ready;
   assign w_load     = w_in_fire & in_last;

   assign w_acc_base = (r_state == ACC) ? r_acc : '0;
   assign w_sum      = SUM_W'(w_acc_base) + SUM_W'(in_data) + SUM_W'(bias);

   always_comb begin
      w_result = w_sum[DATA_W-1:0];
      if (w_sum[SUM_W-1]) begin
         w_result = '0;
      end else if (w_sum > c_POS_MAX) begin
         w_result = c_POS_MAX[DATA_W-1:0];
      end
   end

   assign w_cnt_p1  = {1'b0, r_cnt} + (CNT_W + 1)'(1);
   assign w_len_err = w_in_fire & (in_last ? (w_cnt_p1 != c_N) : (w_cnt_p1 == c_N));

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      if (w_in_fire) begin
         if (in_last) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
         end else begin
            case (r_state)
               IDLE: begin
                  w_state_nxt = ACC;
                  w_acc_nxt   = ACC_W'(in_data);
                  w_cnt_nxt   = CNT_W'(1);
               end
               ACC: begin
                  w_acc_nxt = r_acc + ACC_W'(in_data);
                  w_cnt_nxt = (r_cnt == c_CNT_MAX) ? r_cnt : w_cnt_p1[CNT_W-1:0];
               end
               default: begin
                  w_state_nxt = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A last-beat load wins over a drain, so back-to-back results leave no bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
         end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
         end
         if (w_len_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign beat_cnt  = r_cnt;
   assign err_len   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mlp_acc_bias_relu.sv
// ============================================================================
// Module   : tb_mlp_acc_bias_relu
// Brief    : Self-checking bench: vector table, corner sequences, random model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mlp_acc_bias_relu;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;
   logic [15:0] bias;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [7:0]  beat_cnt;
   logic        err_len;

   int checks   = 0;
   int failures = 0;

   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];

   typedef struct {
      logic [15:0] d;
      logic [15:0] b;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl[8];

   mlp_acc_bias_relu #(
      .DATA_W(16), .ACC_W(24), .N_INPUTS(8), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .bias(bias),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .beat_cnt(beat_cnt), .err_len(err_len)
   );

   always #5 clk = ~clk;

   // Records every result the DUT hands downstream.
   always @(negedge clk) begin
      #2;
      if (reset && ce && out_valid && out_ready) got_q.push_back(out_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic beat(input logic [15:0] d, input logic l, input logic [15:0] b, input bit rnd);
      bit fired;
      int n;
      fired    = 1'b0;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      bias     = b;
      while (!fired && n < 64) begin
         if (rnd) begin
            ce        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
         end
         #1;
         fired = ce && in_ready;
         cyc();
         n++;
      end
      in_valid = 1'b0;
      if (!fired) chk("beat_accept_timeout", 0, 1);
   endtask

   task automatic neuron(input logic [15:0] d, input int n, input logic [15:0] b);
      for (int j = 0; j < n; j++) beat(d, (j == n - 1), b, 1'b0);
   endtask

   function automatic logic [15:0] ref_res(input longint s);
      if (s < 0) return 16'h0000;
      if (s > 32767) return 16'h7FFF;
      return 16'(s);
   endfunction

   initial begin
      tbl[0] = '{16'h0100, 16'h0080, 16'h0880};
      tbl[1] = '{16'hF000, 16'h0000, 16'h0000};
      tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
      tbl[3] = '{16'h0010, 16'h0000, 16'h0080};
      tbl[4] = '{16'h8000, 16'h8000, 16'h0000};
      tbl[5] = '{16'h1000, 16'hFFFF, 16'h7FFF};
      tbl[6] = '{16'h1000, 16'h0000, 16'h7FFF};
      tbl[7] = '{16'hFFFF, 16'h000A, 16'h0002};

      reset = 1'b0; ce = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      bias = '0; out_ready = 1'b1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_err_len", err_len, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      chk("rst_in_ready", in_ready, 1);

      // Table of well-formed 8-beat neurons
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            beat(tbl[i].d, (j == 7), tbl[i].b, 1'b0);
            if (j == 2) chk($sformatf("tbl%0d_cnt3", i), beat_cnt, 3);
         end
         chk($sformatf("tbl%0d_valid", i), out_valid, 1);
         chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp);
         chk($sformatf("tbl%0d_cnt0", i), beat_cnt, 0);
         chk($sformatf("tbl%0d_err", i), err_len, 0);
         cyc();
         chk($sformatf("tbl%0d_pulse", i), out_valid, 0);
      end

      // Short neuron: last on beat 5
      for (int j = 0; j < 4; j++) beat(16'h0100, 1'b0, 16'h0, 1'b0);
      chk("short_err_before", err_len, 0);
      chk("short_cnt4", beat_cnt, 4);
      beat(16'h0100, 1'b1, 16'h0010, 1'b0);
      chk("short_data", out_data, 16'h0510);
      chk("short_err", err_len, 1);
      neuron(16'h0010, 8, 16'h0000);
      chk("sticky_data", out_data, 16'h0080);
      chk("sticky_err", err_len, 1);
      cyc();

      // Backpressure: held result stalls beats; simultaneous drain and load
      out_ready = 1'b0;
      got_q.delete();
      neuron(16'h0020, 8, 16'h0000);
      chk("bp_held_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      in_valid = 1'b1; in_data = 16'h0040; in_last = 1'b0; bias = 16'h0005;
      repeat (3) cyc();
      chk("bp_stall_cnt", beat_cnt, 0);
      chk("bp_stall_data", out_data, 16'h0100);
      in_last = 1'b1; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0; in_last = 1'b0;
      chk("bp_swap_valid", out_valid, 1);
      chk("bp_swap_data", out_data, 16'h0045);
      chk("bp_first_sent", got_q.size(), 1);
      if (got_q.size() > 0) chk("bp_first_data", got_q[0], 16'h0100);
      cyc();
      chk("bp_drained", out_valid, 0);

      // Asynchronous reset with a held result, then mid-neuron
      out_ready = 1'b0;
      neuron(16'h0030, 8, 16'h0000);
      chk("ar_held", out_data, 16'h0180);
      #3 reset = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_data", out_data, 0);
      chk("ar_err", err_len, 0);
      @(negedge clk) reset = 1'b1;
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) beat(16'h7000, 1'b0, 16'h0, 1'b0);
      chk("ar_cnt3", beat_cnt, 3);
      #3 reset = 1'b0;
      #1;
      chk("ar_cnt_clr", beat_cnt, 0);
      @(negedge clk) reset = 1'b1;
      neuron(16'h0010, 8, 16'h0000);
      chk("ar_next_data", out_data, 16'h0080);
      chk("ar_next_err", err_len, 0);
      cyc();

      // Clock enable freezes beats and the output register
      for (int j = 0; j < 3; j++) beat(16'h0010, 1'b0, 16'h0, 1'b0);
      ce = 1'b0; in_valid = 1'b1; in_data = 16'h7000; in_last = 1'b0;
      repeat (4) cyc();
      chk("ce_cnt_hold", beat_cnt, 3);
      in_valid = 1'b0; ce = 1'b1;
      for (int j = 0; j < 5; j++) beat(16'h0010, (j == 4), 16'h0, 1'b0);
      chk("ce_sum", out_data, 16'h0080);
      got_q.delete();
      ce = 1'b0;
      repeat (2) cyc();
      chk("ce_out_hold", out_valid, 1);
      chk("ce_no_fire", got_q.size(), 0);
      ce = 1'b1;
      cyc();
      chk("ce_out_fire", got_q.size(), 1);

      // Random neurons against the reference model
      begin
         bit     exp_err;
         int     len;
         longint sum;
         logic [15:0] d, b;
         exp_err = 1'b0;
         got_q.delete();
         exp_q.delete();
         for (int k = 0; k < 30; k++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : 8;
            if (len != 8) exp_err = 1'b1;
            b   = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
            sum = longint'($signed(b));
            for (int j = 0; j < len; j++) begin
               d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
               sum += longint'($signed(d));
               beat(d, (j == len - 1), b, 1'b1);
            end
            exp_q.push_back(ref_res(sum));
         end
         ce = 1'b1; out_ready = 1'b1;
         repeat (4) cyc();
         chk("rnd_count", got_q.size(), exp_q.size());
         for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk($sformatf("rnd_result%0d", k), got_q[k], exp_q[k]);
         chk("rnd_err", err_len, exp_err);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
